// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle between the pipeline datapath (master) and pipeline_hazard_ctrl (slave).
// Perf counter signals exist only when HAZARD_PERF_CNT_EN is defined.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [3:0] RA1D, RA2D, RA1E, RA2E;
  logic [3:0] WA3E, WA3M, WA3W;
  logic       RegWriteM, RegWriteW;
  logic       MemtoRegE, PCSrc, McOpE, mc_done;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE;
  logic       FlushD, FlushE, FlushM;
  logic       mc_start, mc_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
           RegWriteM, RegWriteW, MemtoRegE, PCSrc, McOpE, mc_done,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
           FlushD, FlushE, FlushM, mc_start, mc_err, stall_cnt, flush_cnt
  );
  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
           RegWriteM, RegWriteW, MemtoRegE, PCSrc, McOpE, mc_done,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
           FlushD, FlushE, FlushM, mc_start, mc_err, stall_cnt, flush_cnt
  );
`else
  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
           RegWriteM, RegWriteW, MemtoRegE, PCSrc, McOpE, mc_done,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
           FlushD, FlushE, FlushM, mc_start, mc_err
  );
  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
           RegWriteM, RegWriteW, MemtoRegE, PCSrc, McOpE, mc_done,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
           FlushD, FlushE, FlushM, mc_start, mc_err
  );
`endif
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Forwarding, load-use stall, branch flush and multicycle-unit sequencing for the 5-stage pipeline.
// Optional saturating perf counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MC_TIMEOUT   = 1024,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  pipeline_hazard_ctrl_if.slave   bus
);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_FLUSH   = 2'd1;
  localparam logic [1:0] S_MC_WAIT = 2'd2;

  localparam int unsigned     FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned     TO_W    = $clog2(MC_TIMEOUT + 1);
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MC_TIMEOUT - 1);
  localparam logic            FC_STAY = (FLUSH_CYCLES > 1);

  logic [1:0]      r_state, w_state_nxt;
  logic [FC_W-1:0] r_fl_cnt, w_fl_cnt_nxt;
  logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
  logic            r_mc_start, w_mc_start_nxt;
  logic            r_mc_err, w_mc_err_nxt;
  logic            w_stall_f, w_stall_d, w_stall_e;
  logic            w_flush_d, w_flush_e, w_flush_m;
  logic            w_load_use;

  function automatic logic [1:0] fwd_sel(input logic [3:0] ra, input logic rw_m,
                                         input logic [3:0] wa_m, input logic rw_w,
                                         input logic [3:0] wa_w);
    if (rw_m && (ra == wa_m) && (wa_m != 4'd15))      return 2'b10;
    else if (rw_w && (ra == wa_w) && (wa_w != 4'd15)) return 2'b01;
    else                                              return 2'b00;
  endfunction

  assign bus.ForwardAE = fwd_sel(bus.RA1E, bus.RegWriteM, bus.WA3M, bus.RegWriteW, bus.WA3W);
  assign bus.ForwardBE = fwd_sel(bus.RA2E, bus.RegWriteM, bus.WA3M, bus.RegWriteW, bus.WA3W);

  assign w_load_use = bus.MemtoRegE && ((bus.RA1D == bus.WA3E) || (bus.RA2D == bus.WA3E));

  always_comb begin
    w_state_nxt    = r_state;
    w_fl_cnt_nxt   = r_fl_cnt;
    w_to_cnt_nxt   = r_to_cnt;
    w_mc_start_nxt = 1'b0;
    w_mc_err_nxt   = r_mc_err;
    w_stall_f      = 1'b0;
    w_stall_d      = 1'b0;
    w_stall_e      = 1'b0;
    w_flush_d      = 1'b0;
    w_flush_e      = 1'b0;
    w_flush_m      = 1'b0;
    case (r_state)
      S_RUN: begin
        if (bus.PCSrc) begin
          w_flush_d    = 1'b1;
          w_flush_e    = 1'b1;
          w_fl_cnt_nxt = FC_LOAD;
          w_state_nxt  = FC_STAY ? S_FLUSH : S_RUN;
        end else if (bus.McOpE) begin
          w_stall_f      = 1'b1;
          w_stall_d      = 1'b1;
          w_stall_e      = 1'b1;
          w_flush_m      = 1'b1;
          w_to_cnt_nxt   = '0;
          w_mc_start_nxt = 1'b1;
          w_state_nxt    = S_MC_WAIT;
        end else if (w_load_use) begin
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_flush_e = 1'b1;
        end
      end
      S_FLUSH: begin
        // Decode/Execute hold wrong-path instructions here, so only a new branch is honoured.
        w_flush_d = 1'b1;
        if (bus.PCSrc) begin
          w_flush_e    = 1'b1;
          w_fl_cnt_nxt = FC_LOAD;
          w_state_nxt  = FC_STAY ? S_FLUSH : S_RUN;
        end else begin
          w_fl_cnt_nxt = r_fl_cnt - FC_W'(1);
          if (r_fl_cnt <= FC_W'(1)) begin
            w_fl_cnt_nxt = '0;
            w_state_nxt  = S_RUN;
          end
        end
      end
      S_MC_WAIT: begin
        if (bus.mc_done) begin
          w_state_nxt = S_RUN;
        end else if (r_to_cnt == TO_LAST) begin
          w_mc_err_nxt = 1'b1;
          w_state_nxt  = S_RUN;
        end else begin
          w_stall_f    = 1'b1;
          w_stall_d    = 1'b1;
          w_stall_e    = 1'b1;
          w_flush_m    = 1'b1;
          w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_RUN;
      r_fl_cnt   <= '0;
      r_to_cnt   <= '0;
      r_mc_start <= 1'b0;
      r_mc_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fl_cnt   <= w_fl_cnt_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_mc_start <= w_mc_start_nxt;
      r_mc_err   <= w_mc_err_nxt;
    end
  end

  // Outputs also decode live inputs, so reset masks them to reach zero without a clock edge.
  assign bus.StallF   = w_stall_f & ~reset;
  assign bus.StallD   = w_stall_d & ~reset;
  assign bus.StallE   = w_stall_e & ~reset;
  assign bus.FlushD   = w_flush_d & ~reset;
  assign bus.FlushE   = w_flush_e & ~reset;
  assign bus.FlushM   = w_flush_m & ~reset;
  assign bus.mc_start = r_mc_start;
  assign bus.mc_err   = r_mc_err;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_f && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_d && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares. Expected control byte order: SF SD SE FD FE FM MS ME.
module tb_pipeline_hazard_ctrl;

  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_LU   = 8'b1100_1000;
  localparam logic [7:0] C_BR   = 8'b0001_1000;
  localparam logic [7:0] C_FD   = 8'b0001_0000;
  localparam logic [7:0] C_MC   = 8'b1110_0100;
  localparam logic [7:0] C_MCS  = 8'b1110_0110;
  localparam logic [7:0] C_ERR  = 8'b0000_0001;

  typedef struct {
    string       name;
    logic [11:0] v;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic clk;
  logic reset;
  exp_t q[$];
  exp_t e;
  int   checks;
  int   errors;
  logic [31:0] m_sc, m_fc;
  logic [11:0] act;

  pipeline_hazard_ctrl_if #(.CNT_W(32)) bus ();

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES (2),
    .MC_TIMEOUT   (16),
    .CNT_W        (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {bus.ForwardAE, bus.ForwardBE, bus.StallF, bus.StallD, bus.StallE,
             bus.FlushD, bus.FlushE, bus.FlushM, bus.mc_start, bus.mc_err};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %b want %b (FA FB SF SD SE FD FE FM MS ME)", e.name, act, e.v);
      end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (bus.stall_cnt !== e.sc) begin
        errors++;
        $display("FAIL %s stall_cnt: got %0d want %0d", e.name, bus.stall_cnt, e.sc);
      end
      checks++;
      if (bus.flush_cnt !== e.fc) begin
        errors++;
        $display("FAIL %s flush_cnt: got %0d want %0d", e.name, bus.flush_cnt, e.fc);
      end
`endif
    end
  end

  task automatic clr();
    bus.RA1D = '0; bus.RA2D = '0; bus.RA1E = '0; bus.RA2E = '0;
    bus.WA3E = '0; bus.WA3M = '0; bus.WA3W = '0;
    bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0; bus.MemtoRegE = 1'b0;
    bus.PCSrc = 1'b0; bus.McOpE = 1'b0; bus.mc_done = 1'b0;
  endtask

  task automatic cyc(input string nm, input logic [3:0] fwd, input logic [7:0] ctl);
    exp_t x;
    x.name = nm;
    x.v    = {fwd, ctl};
    if (reset) begin
      m_sc = '0;
      m_fc = '0;
    end
    x.sc = m_sc;
    x.fc = m_fc;
    q.push_back(x);
    if (!reset) begin
      m_sc = m_sc + {31'd0, ctl[7]};
      m_fc = m_fc + {31'd0, ctl[4]};
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_sc   = '0;
    m_fc   = '0;
    reset  = 1'b1;
    clr();
    @(posedge clk);
    #1;
    cyc("reset", 4'b0000, C_NONE);
    reset = 1'b0;
    cyc("idle", 4'b0000, C_NONE);

    bus.RegWriteM = 1'b1; bus.WA3M = 4'd4; bus.RA1E = 4'd4; bus.RegWriteW = 1'b1; bus.WA3W = 4'd4;
    cyc("fwdA_mem", 4'b1000, C_NONE);
    bus.WA3M = 4'd15;
    cyc("fwdA_wb", 4'b0100, C_NONE);
    bus.RA1E = 4'd15; bus.WA3W = 4'd15;
    cyc("fwd_r15", 4'b0000, C_NONE);
    bus.RA2E = 4'd7; bus.WA3W = 4'd7; bus.WA3M = 4'd3;
    cyc("fwdB_wb", 4'b0001, C_NONE);
    bus.WA3M = 4'd7;
    cyc("fwdB_mem", 4'b0010, C_NONE);
    bus.RegWriteM = 1'b0;
    cyc("fwdB_nowrM", 4'b0001, C_NONE);
    bus.RegWriteW = 1'b0;
    cyc("fwd_nowr", 4'b0000, C_NONE);
    bus.RegWriteM = 1'b1; bus.RA1E = 4'd7;
    cyc("fwdAB_mem", 4'b1010, C_NONE);
    clr();

    bus.MemtoRegE = 1'b1; bus.WA3E = 4'd3; bus.RA2D = 4'd3;
    cyc("lu_rb", 4'b0000, C_LU);
    bus.MemtoRegE = 1'b0;
    cyc("lu_end", 4'b0000, C_NONE);
    bus.MemtoRegE = 1'b1; bus.RA2D = 4'd0; bus.RA1D = 4'd3;
    cyc("lu_ra", 4'b0000, C_LU);
    bus.RA1D = 4'd4; bus.RA2D = 4'd5;
    cyc("lu_none", 4'b0000, C_NONE);
    clr();
    bus.mc_done = 1'b1;
    cyc("done_in_run", 4'b0000, C_NONE);
    clr();

    bus.PCSrc = 1'b1; bus.MemtoRegE = 1'b1; bus.WA3E = 4'd3; bus.RA2D = 4'd3;
    cyc("br_t0", 4'b0000, C_BR);
    bus.PCSrc = 1'b0; bus.McOpE = 1'b1;
    cyc("br_t1", 4'b0000, C_FD);
    clr();
    cyc("br_done", 4'b0000, C_NONE);
    bus.PCSrc = 1'b1;
    cyc("brr_t0", 4'b0000, C_BR);
    cyc("brr_t1", 4'b0000, C_BR);
    bus.PCSrc = 1'b0;
    cyc("brr_t2", 4'b0000, C_FD);
    cyc("brr_end", 4'b0000, C_NONE);

    bus.McOpE = 1'b1;
    cyc("mc_t0", 4'b0000, C_MC);
    cyc("mc_t1", 4'b0000, C_MCS);
    cyc("mc_t2", 4'b0000, C_MC);
    bus.PCSrc = 1'b1;
    cyc("mc_t3_br", 4'b0000, C_MC);
    bus.PCSrc = 1'b0;
    cyc("mc_t4", 4'b0000, C_MC);
    bus.mc_done = 1'b1;
    cyc("mc_t5_done", 4'b0000, C_NONE);
    bus.mc_done = 1'b0; bus.McOpE = 1'b0;
    cyc("mc_after", 4'b0000, C_NONE);

    bus.McOpE = 1'b1;
    cyc("to_t0", 4'b0000, C_MC);
    cyc("to_t1", 4'b0000, C_MCS);
    for (int i = 2; i < 16; i++) cyc("to_wait", 4'b0000, C_MC);
    bus.McOpE = 1'b0;
    cyc("to_release", 4'b0000, C_NONE);
    cyc("to_err", 4'b0000, C_ERR);
    cyc("to_err_sticky", 4'b0000, C_ERR);

    bus.McOpE = 1'b1;
    cyc("rm_t0", 4'b0000, C_MC | C_ERR);
    cyc("rm_t1", 4'b0000, C_MCS | C_ERR);
    cyc("rm_t2", 4'b0000, C_MC | C_ERR);
    reset = 1'b1;
    cyc("rm_reset", 4'b0000, C_NONE);
    reset = 1'b0; bus.McOpE = 1'b0;
    cyc("rm_post", 4'b0000, C_NONE);
    cyc("rm_post2", 4'b0000, C_NONE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
